// File: rtl/matrix_out_read_sequencer_if.sv
// Bundles the result-RAM read port and the outgoing valid/ready word stream
// of the matrix output read sequencer.
interface matrix_out_read_sequencer_if #(
   parameter int DIM = 3,
   parameter int DW  = 16
);
   localparam int AW = (DIM * DIM > 1) ? $clog2(DIM * DIM) : 1;

   logic          ram_rd_en;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_rdata;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;

   modport master (
      output ram_rd_en,
      output ram_addr,
      input  ram_rdata,
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  ram_rd_en,
      input  ram_addr,
      output ram_rdata,
      input  out_data,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/matrix_out_read_sequencer.sv
// Streams a DIM x DIM result matrix out of the output RAM in row-major order,
// hiding the one-cycle RAM read latency behind a 2-entry skid buffer.
module matrix_out_read_sequencer #(
   parameter int DIM = 3,
   parameter int DW  = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic abort,
   output logic busy,
   output logic done,
   matrix_out_read_sequencer_if.master bus
);
   localparam int            AW        = (DIM * DIM > 1) ? $clog2(DIM * DIM) : 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DIM * DIM - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] addr_cnt;
   logic          inflight;
   logic [DW-1:0] buf_mem [2];
   logic          wr_ptr;
   logic          rd_ptr;
   logic [1:0]    buf_cnt;
   logic          rd_en;
   logic          push;
   logic          pop;
   logic          clear;
   logic [2:0]    occ_after;

   assign push  = inflight;
   assign pop   = (buf_cnt != 2'd0) && bus.out_ready;
   assign clear = abort || ((state == S_IDLE) && start);

   // Buffered words plus the read in flight, after this edge's pop; a new read
   // is only issued while this leaves room for its data two edges from now.
   assign occ_after = {1'b0, buf_cnt} + {2'b00, push} - {2'b00, pop};

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_RUN;
         end
         S_RUN: begin
            busy  = 1'b1;
            rd_en = (occ_after <= 3'd1);
            if (rd_en && (addr_cnt == LAST_ADDR)) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (occ_after == 3'd0) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (abort) state_nxt = S_IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // NOTE: the two buffer entries are reset too, since out_data reads the head
   // entry directly and must be 0 out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_cnt   <= '0;
         inflight   <= 1'b0;
         buf_cnt    <= 2'd0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         buf_mem[0] <= '0;
         buf_mem[1] <= '0;
      end else if (clear) begin
         // A read still in flight here is dropped along with the buffer.
         addr_cnt <= '0;
         inflight <= 1'b0;
         buf_cnt  <= 2'd0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
      end else begin
         inflight <= rd_en;
         if (rd_en) addr_cnt <= (addr_cnt == LAST_ADDR) ? '0 : addr_cnt + 1'b1;
         if (push) begin
            buf_mem[wr_ptr] <= bus.ram_rdata;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         buf_cnt <= occ_after[1:0];
      end
   end

   assign bus.ram_rd_en = rd_en;
   assign bus.ram_addr  = addr_cnt;
   assign bus.out_valid = (buf_cnt != 2'd0);
   assign bus.out_data  = buf_mem[rd_ptr];
endmodule

// File: tb/tb_matrix_out_read_sequencer.sv
// Directed bench for matrix_out_read_sequencer: DIM=3, DIM=4 and DIM=1 instances
// fed by simple address-derived RAM models, checked with immediate assertions.
module tb_matrix_out_read_sequencer;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic start3, abort3, busy3, done3;
   logic start4, abort4, busy4, done4;
   logic start1, abort1, busy1, done1;

   matrix_out_read_sequencer_if #(.DIM(3), .DW(16)) b3 ();
   matrix_out_read_sequencer_if #(.DIM(4), .DW(16)) b4 ();
   matrix_out_read_sequencer_if #(.DIM(1), .DW(16)) b1 ();

   matrix_out_read_sequencer #(.DIM(3), .DW(16)) u3 (
      .clk(clk), .rst(rst), .start(start3), .abort(abort3),
      .busy(busy3), .done(done3), .bus(b3)
   );
   matrix_out_read_sequencer #(.DIM(4), .DW(16)) u4 (
      .clk(clk), .rst(rst), .start(start4), .abort(abort4),
      .busy(busy4), .done(done4), .bus(b4)
   );
   matrix_out_read_sequencer #(.DIM(1), .DW(16)) u1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort1),
      .busy(busy1), .done(done1), .bus(b1)
   );

   // RAM models: word at address a is a per-instance base plus a.
   always @(posedge clk) if (b3.ram_rd_en) b3.ram_rdata <= 16'hA000 + 16'(b3.ram_addr);
   always @(posedge clk) if (b4.ram_rd_en) b4.ram_rdata <= 16'hB000 + 16'(b4.ram_addr);
   always @(posedge clk) if (b1.ram_rd_en) b1.ram_rdata <= 16'hC5C5 + 16'(b1.ram_addr);

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic mid;
      @(negedge clk);
   endtask

   task automatic check3(input string tag, input int k, input logic rd, input int addr,
                         input logic vld, input int data, input logic bsy, input logic dn);
      check($sformatf("%s k=%0d rd_en", tag, k), 32'(b3.ram_rd_en), 32'(rd));
      check($sformatf("%s k=%0d addr", tag, k), 32'(b3.ram_addr), 32'(addr));
      check($sformatf("%s k=%0d valid", tag, k), 32'(b3.out_valid), 32'(vld));
      if (vld) check($sformatf("%s k=%0d data", tag, k), 32'(b3.out_data), 32'(data));
      check($sformatf("%s k=%0d busy", tag, k), 32'(busy3), 32'(bsy));
      check($sformatf("%s k=%0d done", tag, k), 32'(done3), 32'(dn));
   endtask

   // Full DIM=3 transfer with ready high; optional start pulses in RUN and DONE.
   task automatic run3(input string tag, input bit poke);
      start3 = 1'b1;
      b3.out_ready = 1'b1;
      mid;
      check({tag, " c0 busy"}, 32'(busy3), 32'd0);
      tick;
      for (int k = 1; k <= 13; k++) begin
         start3 = poke && (k == 4 || k == 12);
         mid;
         check3(tag, k, k <= 9, (k <= 9) ? k - 1 : 0, (k >= 3 && k <= 11),
                32'hA000 + k - 3, k <= 11, k == 12);
         tick;
      end
      start3 = 1'b0;
   endtask

   int          idx;
   int          dones;
   logic        prev_stall;
   logic [15:0] prev_data;

   initial begin
      rst = 1'b1;
      {start3, abort3, start4, abort4, start1, abort1} = '0;
      b3.out_ready = 1'b0;
      b4.out_ready = 1'b0;
      b1.out_ready = 1'b0;
      #2 rst = 1'b0;

      // Reset values
      mid;
      check3("reset", 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
      check("reset data3", 32'(b3.out_data), 32'd0);
      check("reset valid4", 32'(b4.out_valid), 32'd0);
      check("reset busy1", 32'(busy1), 32'd0);
      #2 rst = 1'b1;
      tick;

      // Straight transfer, with start pulses during RUN and DONE that must be ignored
      run3("stream", 1'b1);

      // Backpressure: ready low for 5 cycles while word 1 is at the head
      start3 = 1'b1;
      tick;
      start3 = 1'b0;
      for (int k = 1; k <= 18; k++) begin
         b3.out_ready = !(k >= 4 && k <= 8);
         mid;
         check3("bp", k,
                (k <= 3) || (k >= 9 && k <= 14),
                (k <= 3) ? k - 1 : (k <= 8) ? 3 : (k <= 14) ? k - 6 : 0,
                (k >= 3 && k <= 16),
                (k == 3) ? 32'hA000 : (k <= 8) ? 32'hA001 : 32'hA000 + k - 8,
                k <= 16, k == 17);
         tick;
      end

      // Abort with addr=4 and both buffer entries occupied
      start3 = 1'b1;
      tick;
      start3 = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         b3.out_ready = (k <= 4);
         abort3 = (k == 6);
         mid;
         if (k == 5) check("abort k=5 rd_en", 32'(b3.ram_rd_en), 32'd0);
         if (k == 6) begin
            check("abort pre addr", 32'(b3.ram_addr), 32'd4);
            check("abort pre buf_cnt", 32'(u3.buf_cnt), 32'd2);
            check("abort pre data", 32'(b3.out_data), 32'hA002);
         end
         if (k >= 7) check3("abort", k, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
         tick;
      end
      abort3 = 1'b0;
      run3("post_abort", 1'b0);

      // start and abort together in IDLE: abort wins
      start3 = 1'b1;
      abort3 = 1'b1;
      tick;
      start3 = 1'b0;
      abort3 = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         mid;
         check3("start_abort", k, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
         tick;
      end

      // Random ready on DIM=4 with an in-order scoreboard
      start4 = 1'b1;
      tick;
      start4 = 1'b0;
      idx = 0;
      dones = 0;
      prev_stall = 1'b0;
      prev_data = '0;
      for (int c = 0; c < 150; c++) begin
         b4.out_ready = 1'($urandom_range(0, 1));
         mid;
         if (prev_stall) begin
            check($sformatf("rnd c=%0d held valid", c), 32'(b4.out_valid), 32'd1);
            check($sformatf("rnd c=%0d held data", c), 32'(b4.out_data), 32'(prev_data));
         end
         if (b4.out_valid && b4.out_ready) begin
            check($sformatf("rnd word %0d", idx), 32'(b4.out_data), 32'hB000 + idx);
            idx++;
         end
         check($sformatf("rnd c=%0d buf_cnt<=2", c), 32'(u4.buf_cnt <= 2'd2), 32'd1);
         if (done4) dones++;
         prev_stall = b4.out_valid && !b4.out_ready;
         prev_data  = b4.out_data;
         tick;
      end
      check("rnd word count", 32'(idx), 32'd16);
      check("rnd done count", 32'(dones), 32'd1);
      check("rnd idle busy", 32'(busy4), 32'd0);

      // Reset asserted mid-DRAIN, then stale RAM data must not leak out
      start3 = 1'b1;
      b3.out_ready = 1'b1;
      tick;
      start3 = 1'b0;
      for (int k = 1; k <= 9; k++) tick;
      check("rst pre drain busy", 32'(busy3), 32'd1);
      check("rst pre drain rd_en", 32'(b3.ram_rd_en), 32'd0);
      #2 rst = 1'b0;
      #1;
      check3("rst_async", 10, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
      check("rst_async data", 32'(b3.out_data), 32'd0);
      mid;
      rst = 1'b1;
      tick;
      for (int k = 1; k <= 4; k++) begin
         mid;
         check3("post_rst", k, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
         check($sformatf("post_rst k=%0d data", k), 32'(b3.out_data), 32'd0);
         tick;
      end

      // DIM=1: one read, one word, one done pulse
      start1 = 1'b1;
      b1.out_ready = 1'b1;
      tick;
      start1 = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         mid;
         check($sformatf("dim1 k=%0d rd_en", k), 32'(b1.ram_rd_en), 32'(k == 1));
         check($sformatf("dim1 k=%0d addr", k), 32'(b1.ram_addr), 32'd0);
         check($sformatf("dim1 k=%0d valid", k), 32'(b1.out_valid), 32'(k == 3));
         if (k == 3) check("dim1 data", 32'(b1.out_data), 32'hC5C5);
         check($sformatf("dim1 k=%0d busy", k), 32'(busy1), 32'(k <= 3));
         check($sformatf("dim1 k=%0d done", k), 32'(done1), 32'(k == 4));
         tick;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
